// File: rtl/msg_rx_pkg.sv
// Shared definitions for the receive message controller: FSM encoding and
// default header constants also used by the transmit side.
package msg_rx_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RECV  = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;
    localparam logic [1:0] ST_ABORT = 2'd3;

    localparam logic [15:0] DEF_SYNC      = 16'h1234;
    localparam logic [15:0] DEF_ID1       = 16'd101;
    localparam logic [15:0] DEF_ID2       = 16'd102;
    localparam logic [15:0] DEF_HDR_BYTES = 16'd8;
    localparam logic [15:0] DEF_MAX_BYTES = 16'd264;

    // Sequence numbers wrap modulo 2^16, so FFFF -> 0000 is contiguous.
    function automatic logic seq_is_gap(input logic [15:0] last_seq, input logic [15:0] seq);
        return seq != (last_seq + 16'd1);
    endfunction

endpackage

// File: rtl/msg_rx_controller_if.sv
// Router/consumer-facing signal bundle of msg_rx_controller.
interface msg_rx_controller_if;

    logic        MessageByteReady;
    logic [15:0] SyncWord;
    logic [15:0] MessageID;
    logic [15:0] ByteCount;
    logic [15:0] SequenceNumber;
    logic        MessageComplete;
    logic        Msg1Ack;
    logic        Msg2Ack;
    logic        StatusClear;

    logic        RouterClear;
    logic        Msg1Ready;
    logic        Msg2Ready;
    logic        CmdStrobe;
    logic [15:0] CmdID;
    logic [15:0] LastSeq;
    logic        SeqGap;
    logic        Overrun1;
    logic        Overrun2;
    logic [7:0]  ErrorCount;

    modport master (
        output MessageByteReady, SyncWord, MessageID, ByteCount, SequenceNumber,
        output MessageComplete, Msg1Ack, Msg2Ack, StatusClear,
        input  RouterClear, Msg1Ready, Msg2Ready, CmdStrobe, CmdID, LastSeq,
        input  SeqGap, Overrun1, Overrun2, ErrorCount
    );

    modport slave (
        input  MessageByteReady, SyncWord, MessageID, ByteCount, SequenceNumber,
        input  MessageComplete, Msg1Ack, Msg2Ack, StatusClear,
        output RouterClear, Msg1Ready, Msg2Ready, CmdStrobe, CmdID, LastSeq,
        output SeqGap, Overrun1, Overrun2, ErrorCount
    );

endinterface

// File: rtl/msg_timeout_counter.sv
// Restartable idle counter; o_expired flags the increment that reaches TIMEOUT.
module msg_timeout_counter #(
    parameter int unsigned TIMEOUT = 50000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_restart,
    input  logic i_inc,
    output logic o_expired
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);
    localparam logic [CW-1:0] LAST  = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_restart) begin
            r_count <= '0;
        end else if (i_inc && r_count != LIMIT) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = i_inc && !i_restart && (r_count == LAST);

endmodule

// File: rtl/msg_rx_controller.sv
// Receive message sequencer: validates completed headers, hands data buffers
// to the consumer, strobes header-only commands and aborts stalled messages.
module msg_rx_controller
    import msg_rx_pkg::*;
#(
    parameter logic [15:0] SYNC       = DEF_SYNC,
    parameter logic [15:0] ID1        = DEF_ID1,
    parameter logic [15:0] ID2        = DEF_ID2,
    parameter logic [15:0] HDR_BYTES  = DEF_HDR_BYTES,
    parameter logic [15:0] MAX_BYTES1 = DEF_MAX_BYTES,
    parameter logic [15:0] MAX_BYTES2 = DEF_MAX_BYTES,
    parameter int unsigned TIMEOUT    = 50000
) (
    input logic               i_clock,
    input logic               i_clear,
    msg_rx_controller_if.slave bus
);

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic        r_first;
    logic [15:0] r_last_seq;
    logic        r_seq_gap;
    logic        r_ready1;
    logic        r_ready2;
    logic        r_ovr1;
    logic        r_ovr2;
    logic        r_cmd_strobe;
    logic [15:0] r_cmd_id;
    logic        r_router_clear;
    logic [7:0]  r_err_count;

    logic w_expired;
    logic w_in_check;
    logic w_sync_ok;
    logic w_is_id1;
    logic w_is_id2;
    logic w_acc1;
    logic w_acc2;
    logic w_acc_cmd;
    logic w_accept;
    logic w_enter_abort;

    // Held at zero outside RECV; each byte strobe restarts the idle window.
    msg_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .i_clk     (i_clock),
        .i_rst     (i_clear),
        .i_restart ((r_state != ST_RECV) || bus.MessageByteReady),
        .i_inc     (r_state == ST_RECV),
        .o_expired (w_expired)
    );

    assign w_in_check = (r_state == ST_CHECK);
    assign w_sync_ok  = (bus.SyncWord == SYNC);
    assign w_is_id1   = (bus.MessageID == ID1);
    assign w_is_id2   = (bus.MessageID == ID2);
    assign w_acc1     = w_in_check && w_sync_ok && w_is_id1 && (bus.ByteCount <= MAX_BYTES1);
    assign w_acc2     = w_in_check && w_sync_ok && w_is_id2 && (bus.ByteCount <= MAX_BYTES2);
    assign w_acc_cmd  = w_in_check && w_sync_ok && !w_is_id1 && !w_is_id2 &&
                        (bus.ByteCount == HDR_BYTES);
    assign w_accept   = w_acc1 || w_acc2 || w_acc_cmd;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.MessageComplete)       w_state_next = ST_CHECK;
                else if (bus.MessageByteReady) w_state_next = ST_RECV;
            end
            ST_RECV: begin
                if (bus.MessageComplete) w_state_next = ST_CHECK;
                else if (w_expired)      w_state_next = ST_ABORT;
            end
            ST_CHECK: w_state_next = w_accept ? ST_IDLE : ST_ABORT;
            ST_ABORT: w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    assign w_enter_abort = (w_state_next == ST_ABORT);

    always_ff @(posedge i_clock or posedge i_clear) begin
        if (i_clear) begin
            r_state        <= ST_IDLE;
            r_first        <= 1'b1;
            r_last_seq     <= '0;
            r_seq_gap      <= 1'b0;
            r_ready1       <= 1'b0;
            r_ready2       <= 1'b0;
            r_ovr1         <= 1'b0;
            r_ovr2         <= 1'b0;
            r_cmd_strobe   <= 1'b0;
            r_cmd_id       <= '0;
            r_router_clear <= 1'b0;
            r_err_count    <= '0;
        end else begin
            r_state        <= w_state_next;
            r_router_clear <= w_enter_abort;
            r_cmd_strobe   <= w_acc_cmd;

            if (w_acc_cmd) r_cmd_id <= bus.MessageID;

            if (w_accept) begin
                r_last_seq <= bus.SequenceNumber;
                r_first    <= 1'b0;
            end

            if (w_acc1)           r_ready1 <= 1'b1;
            else if (bus.Msg1Ack) r_ready1 <= 1'b0;
            if (w_acc2)           r_ready2 <= 1'b1;
            else if (bus.Msg2Ack) r_ready2 <= 1'b0;

            // Clearing the sticky status takes precedence over any new event.
            if (bus.StatusClear) begin
                r_seq_gap   <= 1'b0;
                r_ovr1      <= 1'b0;
                r_ovr2      <= 1'b0;
                r_err_count <= '0;
            end else begin
                if (w_accept && !r_first && seq_is_gap(r_last_seq, bus.SequenceNumber)) begin
                    r_seq_gap <= 1'b1;
                end
                if (w_acc1 && r_ready1 && !bus.Msg1Ack) r_ovr1 <= 1'b1;
                if (w_acc2 && r_ready2 && !bus.Msg2Ack) r_ovr2 <= 1'b1;
                if (w_enter_abort && r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
            end
        end
    end

    assign bus.RouterClear = r_router_clear;
    assign bus.Msg1Ready   = r_ready1;
    assign bus.Msg2Ready   = r_ready2;
    assign bus.CmdStrobe   = r_cmd_strobe;
    assign bus.CmdID       = r_cmd_id;
    assign bus.LastSeq     = r_last_seq;
    assign bus.SeqGap      = r_seq_gap;
    assign bus.Overrun1    = r_ovr1;
    assign bus.Overrun2    = r_ovr2;
    assign bus.ErrorCount  = r_err_count;

endmodule

// File: tb/tb_msg_rx_controller.sv
// Randomised self-checking bench for msg_rx_controller against a
// message-level reference model.
module tb_msg_rx_controller;

    localparam int unsigned TO = 20;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    msg_rx_controller_if bus ();

    msg_rx_controller #(
        .TIMEOUT (TO)
    ) dut (
        .i_clock (clk),
        .i_clear (rst),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state, one update per message/handshake event.
    bit          m_ready1, m_ready2, m_first, m_gap, m_ovr1, m_ovr2;
    logic [15:0] m_last, m_cmd_id;
    int          m_err;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_ready1 = 0; m_ready2 = 0; m_first = 1; m_gap = 0; m_ovr1 = 0; m_ovr2 = 0;
        m_last = '0; m_cmd_id = '0; m_err = 0;
    endtask

    task automatic idle_inputs();
        bus.MessageByteReady = 0; bus.MessageComplete = 0;
        bus.Msg1Ack = 0; bus.Msg2Ack = 0; bus.StatusClear = 0;
    endtask

    // 0 = reject, 1 = data buffer 1, 2 = data buffer 2, 3 = command
    function automatic int classify(input logic [15:0] sync, input logic [15:0] id,
                                    input logic [15:0] bc);
        if (sync != 16'h1234) return 0;
        if (id == 16'd101) return (bc <= 16'd264) ? 1 : 0;
        if (id == 16'd102) return (bc <= 16'd264) ? 2 : 0;
        return (bc == 16'd8) ? 3 : 0;
    endfunction

    task automatic check_status(input string tag);
        check_eq({tag, ".rdy1"}, bus.Msg1Ready, m_ready1);
        check_eq({tag, ".rdy2"}, bus.Msg2Ready, m_ready2);
        check_eq({tag, ".last"}, bus.LastSeq, m_last);
        check_eq({tag, ".gap"}, bus.SeqGap, m_gap);
        check_eq({tag, ".ovr1"}, bus.Overrun1, m_ovr1);
        check_eq({tag, ".ovr2"}, bus.Overrun2, m_ovr2);
        check_eq({tag, ".err"}, bus.ErrorCount, m_err);
        check_eq({tag, ".cmdid"}, bus.CmdID, m_cmd_id);
    endtask

    task automatic send_msg(input string tag, input logic [15:0] sync, input logic [15:0] id,
                            input logic [15:0] bc, input logic [15:0] seq, input int nbytes,
                            input bit ack1, input bit ack2, input int max_gap);
        int cls;
        for (int i = 0; i < nbytes; i++) begin
            bus.MessageByteReady = 1;
            tick();
            bus.MessageByteReady = 0;
            repeat ($urandom_range(max_gap, 0)) tick();
        end
        bus.SyncWord = sync; bus.MessageID = id; bus.ByteCount = bc; bus.SequenceNumber = seq;
        bus.MessageComplete = 1;
        tick();
        bus.MessageComplete = 0;
        bus.Msg1Ack = ack1; bus.Msg2Ack = ack2;
        tick();
        bus.Msg1Ack = 0; bus.Msg2Ack = 0;

        cls = classify(sync, id, bc);
        if (cls != 0) begin
            if (!m_first && seq != 16'(m_last + 1)) m_gap = 1;
            m_last = seq;
            m_first = 0;
        end else begin
            m_err = (m_err < 255) ? m_err + 1 : 255;
        end
        if (cls == 1) begin
            if (m_ready1 && !ack1) m_ovr1 = 1;
            m_ready1 = 1;
        end else if (ack1) m_ready1 = 0;
        if (cls == 2) begin
            if (m_ready2 && !ack2) m_ovr2 = 1;
            m_ready2 = 1;
        end else if (ack2) m_ready2 = 0;
        if (cls == 3) m_cmd_id = id;

        check_eq({tag, ".rclr"}, bus.RouterClear, cls == 0);
        check_eq({tag, ".cmd"}, bus.CmdStrobe, cls == 3);
        check_status(tag);
        tick();
        check_eq({tag, ".rclr_end"}, bus.RouterClear, 0);
        check_eq({tag, ".cmd_end"}, bus.CmdStrobe, 0);
    endtask

    task automatic ack_buf(input string tag, input int ch);
        if (ch == 1) bus.Msg1Ack = 1; else bus.Msg2Ack = 1;
        tick();
        bus.Msg1Ack = 0; bus.Msg2Ack = 0;
        if (ch == 1) m_ready1 = 0; else m_ready2 = 0;
        check_eq({tag, ".rdy1"}, bus.Msg1Ready, m_ready1);
        check_eq({tag, ".rdy2"}, bus.Msg2Ready, m_ready2);
    endtask

    task automatic status_clear(input string tag);
        bus.StatusClear = 1;
        tick();
        bus.StatusClear = 0;
        m_gap = 0; m_ovr1 = 0; m_ovr2 = 0; m_err = 0;
        check_status(tag);
    endtask

    task automatic timeout_test();
        int n;
        n = 0;
        for (int i = 0; i < 3; i++) begin
            bus.MessageByteReady = 1;
            tick();
        end
        bus.MessageByteReady = 0;
        while (bus.RouterClear !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check_eq("timeout.clocks", n, TO);
        m_err = (m_err < 255) ? m_err + 1 : 255;
        check_status("timeout");
        tick();
        check_eq("timeout.rclr_end", bus.RouterClear, 0);
    endtask

    logic [15:0] ids[4] = '{16'd101, 16'd102, 16'd200, 16'd7};
    logic [15:0] bcs[6] = '{16'd8, 16'd12, 16'd20, 16'd264, 16'd265, 16'd0};

    initial begin
        logic [15:0] r_sync, r_id, r_bc, r_seq;
        idle_inputs();
        bus.SyncWord = 0; bus.MessageID = 0; bus.ByteCount = 0; bus.SequenceNumber = 0;
        model_reset();
        rst = 1;
        repeat (3) tick();
        check_eq("reset.rclr", bus.RouterClear, 0);
        check_eq("reset.cmd", bus.CmdStrobe, 0);
        check_status("reset");
        rst = 0;
        tick();

        send_msg("id1", 16'h1234, 16'd101, 16'd20, 16'd5, 3, 0, 0, 2);
        ack_buf("ack1", 1);
        send_msg("badsync", 16'hABCD, 16'd102, 16'd20, 16'd6, 2, 0, 0, 1);
        send_msg("ovr.a", 16'h1234, 16'd101, 16'd20, 16'd6, 2, 0, 0, 1);
        send_msg("ovr.b", 16'h1234, 16'd101, 16'd20, 16'd7, 2, 0, 0, 1);
        status_clear("sclr1");
        send_msg("ovr.ack", 16'h1234, 16'd101, 16'd20, 16'd8, 2, 1, 0, 1);
        send_msg("gap", 16'h1234, 16'd102, 16'd264, 16'd10, 1, 0, 0, 0);
        send_msg("wrap.a", 16'h1234, 16'd102, 16'd20, 16'hFFFF, 1, 1, 0, 0);
        status_clear("sclr2");
        send_msg("wrap.b", 16'h1234, 16'd101, 16'd20, 16'h0000, 0, 0, 1, 0);
        send_msg("len1", 16'h1234, 16'd101, 16'd265, 16'd1, 1, 0, 0, 0);
        timeout_test();
        send_msg("cmd", 16'h1234, 16'd200, 16'd8, 16'd1, 2, 0, 0, 0);
        send_msg("cmdbad", 16'h1234, 16'd200, 16'd12, 16'd2, 2, 0, 0, 0);

        // Asynchronous clear in the middle of a message.
        bus.MessageByteReady = 1;
        tick();
        tick();
        bus.MessageByteReady = 0;
        #2;
        rst = 1;
        #1;
        model_reset();
        check_eq("aclr.rclr", bus.RouterClear, 0);
        check_eq("aclr.cmd", bus.CmdStrobe, 0);
        check_status("aclr");
        #1;
        rst = 0;
        tick();
        send_msg("postclr", 16'h1234, 16'd102, 16'd30, 16'd77, 2, 0, 0, 1);

        for (int k = 0; k < 300; k++) begin
            r_sync = ($urandom_range(9, 0) == 0) ? 16'($urandom) : 16'h1234;
            r_id   = ($urandom_range(7, 0) == 0) ? 16'($urandom) : ids[$urandom_range(3, 0)];
            r_bc   = bcs[$urandom_range(5, 0)];
            r_seq  = ($urandom_range(3, 0) == 0) ? 16'($urandom) : 16'(m_last + 1);
            send_msg("rnd", r_sync, r_id, r_bc, r_seq, $urandom_range(6, 0),
                     $urandom_range(3, 0) == 0, $urandom_range(3, 0) == 0, 3);
            if ($urandom_range(2, 0) == 0) ack_buf("rnd.ack", $urandom_range(2, 1));
            if ($urandom_range(19, 0) == 0) status_clear("rnd.sclr");
        end

        status_clear("sat.pre");
        for (int k = 0; k < 258; k++) begin
            send_msg("sat", 16'h0000, 16'd101, 16'd20, 16'd1, 1, 0, 0, 0);
        end
        check_eq("sat.final", bus.ErrorCount, 8'd255);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/msg_rx_controller.md
Name: msg_rx_controller

Overview:
- Sequences the receive message router. It watches MessageByteReady and the decoded header outputs (SyncWord, MessageID, ByteCount, SequenceNumber, MessageComplete).
- After each complete message it validates the header and hands one of two data-message buffers to its consumer with a ready/ack handshake, or strobes a header-only command.
- Detects stalled messages by timeout and clears the router. Tracks sequence gaps, overruns and an error count for status readback.

Parameters:
- SYNC, 16'h1234, required sync word
- ID1, 16'd101, data message 1 ID
- ID2, 16'd102, data message 2 ID
- HDR_BYTES, 16'd8, ByteCount of a header-only message
- MAX_BYTES1, 16'd264, largest legal ByteCount for ID1
- MAX_BYTES2, 16'd264, largest legal ByteCount for ID2
- TIMEOUT, 50000, idle clocks mid-message before abort (counter width = clog2(TIMEOUT+1))

Ports:
- Clock  in  1  system clock
- Clear  in  1  asynchronous active-high reset
- MessageByteReady  in  1  byte strobe from serial-to-parallel
- SyncWord  in  16  from router
- MessageID  in  16  from router
- ByteCount  in  16  from router
- SequenceNumber  in  16  from router
- MessageComplete  in  1  from router, 1-cycle pulse
- Msg1Ack  in  1  consumer done with buffer 1
- Msg2Ack  in  1  consumer done with buffer 2
- StatusClear  in  1  sync clear of sticky flags and count
- RouterClear  out  1  1-cycle clear to router on abort
- Msg1Ready  out  1  buffer 1 holds a valid message
- Msg2Ready  out  1  buffer 2 holds a valid message
- CmdStrobe  out  1  1-cycle pulse, valid header-only message
- CmdID  out  16  MessageID latched with CmdStrobe
- LastSeq  out  16  SequenceNumber of last accepted message
- SeqGap  out  1  sticky; accepted seq != LastSeq+1
- Overrun1  out  1  sticky; ID1 accepted while Msg1Ready=1
- Overrun2  out  1  sticky; ID2 accepted while Msg2Ready=1
- ErrorCount  out  8  saturating count of rejected/aborted messages

Behaviour:
- Reset (Clear=1, async): all outputs 0, state IDLE, timeout counter 0, "first message" flag set.

State machine:
- IDLE: first MessageByteReady -> RECV, counter 0.
- RECV:
  - each MessageByteReady resets the counter; otherwise it increments.
  - counter reaches TIMEOUT -> ABORT.
  - MessageComplete -> CHECK.
- CHECK, one cycle, evaluates in priority order:
  - SyncWord != SYNC -> reject.
  - ID1 with ByteCount > MAX_BYTES1, or ID2 with ByteCount > MAX_BYTES2 -> reject.
  - ID1/ID2 otherwise -> accept as data.
  - other ID with ByteCount == HDR_BYTES -> accept as command.
  - else reject.
  - Next state is IDLE on accept and ABORT on reject.
- ABORT: RouterClear=1 for exactly one cycle, ErrorCount+1 (holds at 255), -> IDLE.

Accept actions, registered at CHECK exit:
- LastSeq <= SequenceNumber.
- SeqGap set if the first-message flag is clear and SequenceNumber != LastSeq+1 (16-bit wrap: FFFF -> 0000 is not a gap). The first-message flag then clears.
- Data ID1: if Msg1Ready already 1 and Msg1Ack not asserted that cycle, set Overrun1. Msg1Ready <= 1. ID2 handled the same way with Msg2/Overrun2.
- Command: CmdStrobe=1 one cycle, CmdID <= MessageID.

Handshake and latency:
- Msg1Ready falls the cycle after Msg1Ack=1. Ack while Ready=0 is ignored.
- Ack in the same cycle as a new ID1 accept: Ready stays 1, no overrun.
- Latency MessageComplete -> Ready/CmdStrobe/RouterClear is 2 clocks (CHECK, then registered output).
- MessageComplete in IDLE (0-byte edge case) -> CHECK directly.
- MessageComplete coincident with timeout expiry: MessageComplete wins.

Status:
- StatusClear clears SeqGap, Overrun1, Overrun2 and ErrorCount. It does not clear Ready, LastSeq or state.
- StatusClear in the same cycle as an increment or set: clear wins.

Decomposition:
- Package msg_rx_pkg: state encoding (IDLE, RECV, CHECK, ABORT), default SYNC/ID/HDR_BYTES constants shared with the transmit side.
- One natural sub-module: msg_timeout_counter, a loadable/restartable counter with an expiry flag parameterised by TIMEOUT. Everything else inline.

Test Plan:
- Valid ID1, SyncWord=1234h, ByteCount=20, Seq=5 -> Msg1Ready=1 two clocks after MessageComplete, LastSeq=5. Msg1Ack -> Ready=0 next clock.
- Bad sync 0xABCD, ID2 -> RouterClear 1-cycle pulse, ErrorCount=1, Msg2Ready stays 0, LastSeq unchanged.
- Second ID1 without ack -> Overrun1=1, Msg1Ready=1. Repeat with Msg1Ack coincident with the accept -> Overrun1 stays 0.
- Seq 7 then 9 -> SeqGap=1. Seq FFFFh then 0000h after StatusClear -> SeqGap=0.
- Three bytes then silence for TIMEOUT clocks (use TIMEOUT=20) -> RouterClear pulse at clock 20, state IDLE, ErrorCount+1. Assert Clear mid-RECV -> all outputs 0 immediately.
- ID=200, ByteCount=8 -> CmdStrobe one cycle with CmdID=200. ID=200, ByteCount=12 -> reject. 256 rejects -> ErrorCount saturates at 255.
